wrr_arbiter: RTL and testbench
==============================

Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter.
- Successor to the single-grant round-robin arbiter: it adds per-client burst weights, grant hold with credit counting, and stall freeze.
- Sits between N request sources and one shared resource.
- Registered one-hot grant plus encoded grant index, so downstream logic and formal properties see glitch-free outputs.

Parameters:
- CLIENTS, 32, number of requesters (2..64).
- WEIGHT_W, 4, width of each per-client weight field.
- IDX_W, $clog2(CLIENTS), width of grant_idx (derived; do not override).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- request  input  CLIENTS  per-client request level. A client holds request until granted.
- weight  input  CLIENTS*WEIGHT_W  per-client burst length; field i is weight[i*WEIGHT_W +: WEIGHT_W].
- stall  input  1  freezes all arbiter state when high.
- grant  output  CLIENTS  registered one-hot grant, or all-zero when idle.
- grant_valid  output  1  registered; equals |grant.
- grant_idx  output  IDX_W  registered index of the granted client; 0 when grant_valid is 0.
- credit  output  WEIGHT_W  registered remaining cycles in the current burst, including the current cycle; 0 when idle.

Behaviour:
- Reset (synchronous, high at a posedge) forces these values on the next cycle:
  - grant=0, grant_valid=0, grant_idx=0, credit=0.
  - last-owner pointer = CLIENTS-1, so client 0 has highest priority first.
  - Reset mid-burst aborts the burst with no residual state.
- Latency: grant at cycle t+1 is a function of request, weight, stall and state sampled at edge t. No combinational path from inputs to outputs.
- stall=1: grant, grant_idx, grant_valid, credit and the pointer all hold. Request and weight are ignored that cycle. Stall has priority over everything except reset.
- stall=0, current owner o exists, request[o]=1, credit>1: grant held on o, credit decrements by 1.
- stall=0 with any of: no owner, credit==1, or request[o]=0 → re-arbitrate:
  - Search for the first requester strictly after the pointer, modulo CLIENTS, wrapping.
  - The previous owner is eligible only after all others. If it is the sole requester it is regranted.
  - A new winner w loads credit = weight[w]; a zero weight is treated as 1.
  - The pointer updates to w.
  - No requester: grant goes to 0 and the pointer is unchanged.
- Mutual exclusion: at most one grant bit set in every cycle.
- A client with request low at edge t never holds grant at t+1.
- Fairness bound: a continuously requesting client is granted within (CLIENTS-1)*max_weight + 1 non-stalled cycles.
- Weight changes take effect only at the next burst load; an in-flight credit is never modified by a weight change.
- Credit arithmetic is unsigned WEIGHT_W. Decrement occurs only when credit>1, so no underflow or wrap.

Decomposition:
- Package wrr_arbiter_pkg:
  - function onehot_to_idx;
  - function sat_weight (zero → 1);
  - localparam DEFAULT_WEIGHT_W.
- Sub-module rr_pick (combinational, parameter CLIENTS): inputs request vector and pointer; outputs one-hot winner and found flag. Implemented with the double-width rotate and mask technique.
- Top level holds grant, credit and pointer registers and the hold/re-arbitrate control.

Test Plan (CLIENTS=4, WEIGHT_W=3 unless noted):
- Reset, then request=4'b1111, all weights=1, no stall → grant sequence 0001,0010,0100,1000,0001. grant_idx 0,1,2,3,0. credit=1 each cycle.
- weights {3,1,2,1} (client0=3), request=4'b0101 held → grant 0001 ×3 cycles (credit 3,2,1), then 0100 ×2 (credit 2,1), then 0001 again.
- Client 2 granted with weight 4, drops request after cycle 2 of the burst → the next-cycle grant moves to the next requester; credit reloads from the new owner's weight.
- stall=1 for 3 cycles mid-burst (credit=2, grant=0010) → grant, grant_idx and credit hold at 0010/1/2 throughout. After stall drops, credit steps to 1, then the grant rotates.
- Weight field = 0 for client 1, request=4'b0010 only → grant 0010 every cycle, credit=1, pointer stays 1. Then request=0 → grant=0, grant_valid=0, credit=0 on the next cycle.
- Reset asserted while grant=1000 with credit=3 → the next cycle shows all outputs zero. request=4'b1001 then yields grant 0001 first (pointer restored to CLIENTS-1).

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Helpers work on the widest legal vectors; callers zero-extend and truncate.
package wrr_arbiter_pkg;

   localparam int DEFAULT_WEIGHT_W = 4;
   localparam int MAX_CLIENTS      = 64;
   localparam int MAX_IDX_W        = 6;
   localparam int MAX_WEIGHT_W     = 16;

   typedef enum logic [1:0] {
      ACT_FREEZE,
      ACT_HOLD,
      ACT_LOAD,
      ACT_IDLE
   } arb_action_e;

   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
         if (oh[i]) idx |= MAX_IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [MAX_WEIGHT_W-1:0] sat_weight(input logic [MAX_WEIGHT_W-1:0] w);
      return (w == '0) ? MAX_WEIGHT_W'(1) : w;
   endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester strictly after pointer_i,
// wrapping, so the pointer's own client is considered last.
module rr_pick #(
   parameter int CLIENTS = 32,
   parameter int IDX_W   = $clog2(CLIENTS)
) (
   input  logic [CLIENTS-1:0] request_i,
   input  logic [IDX_W-1:0]   pointer_i,
   output logic [CLIENTS-1:0] winner_o,
   output logic               found_o
);

   logic [IDX_W:0]     shamt;
   logic [CLIENTS-1:0] rot;
   logic [CLIENTS-1:0] pick;

   // Rotate so client pointer+1 sits at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      shamt    = {1'b0, pointer_i} + (IDX_W+1)'(1);
      rot      = CLIENTS'({request_i, request_i} >> shamt);
      pick     = rot & (~rot + CLIENTS'(1));
      winner_o = CLIENTS'(({pick, pick} << shamt) >> CLIENTS);
      found_o  = |request_i;
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant held for a burst of
// weight[w] cycles while the owner keeps requesting; stall freezes all state.
module wrr_arbiter
   import wrr_arbiter_pkg::*;
#(
   parameter int CLIENTS  = 32,
   parameter int WEIGHT_W = DEFAULT_WEIGHT_W,
   parameter int IDX_W    = $clog2(CLIENTS)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CLIENTS-1:0]             request,
   input  logic [CLIENTS*WEIGHT_W-1:0]    weight,
   input  logic                           stall,
   output logic [CLIENTS-1:0]             grant,
   output logic                           grant_valid,
   output logic [IDX_W-1:0]               grant_idx,
   output logic [WEIGHT_W-1:0]            credit
);

   logic [CLIENTS-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WEIGHT_W-1:0] credit_q, credit_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;

   logic [CLIENTS-1:0]  win;
   logic                found;
   logic [IDX_W-1:0]    win_idx;
   logic [WEIGHT_W-1:0] win_weight;
   logic [WEIGHT_W-1:0] load_credit;
   arb_action_e         action;

   rr_pick #(
      .CLIENTS (CLIENTS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .request_i (request),
      .pointer_i (ptr_q),
      .winner_o  (win),
      .found_o   (found)
   );

   always_comb begin
      win_weight = '0;
      for (int unsigned i = 0; i < CLIENTS; i++) begin
         if (win[i]) win_weight = weight[i*WEIGHT_W +: WEIGHT_W];
      end
      win_idx     = IDX_W'(onehot_to_idx(MAX_CLIENTS'(win)));
      load_credit = WEIGHT_W'(sat_weight(MAX_WEIGHT_W'(win_weight)));
   end

   // Owner still requesting implies an owner exists, since grant_q is zero when idle.
   always_comb begin
      if (stall)
         action = ACT_FREEZE;
      else if (|(request & grant_q) && credit_q > WEIGHT_W'(1))
         action = ACT_HOLD;
      else if (found)
         action = ACT_LOAD;
      else
         action = ACT_IDLE;
   end

   always_comb begin
      grant_d  = grant_q;
      idx_d    = idx_q;
      credit_d = credit_q;
      ptr_d    = ptr_q;
      unique case (action)
         ACT_FREEZE: ;
         ACT_HOLD:   credit_d = credit_q - WEIGHT_W'(1);
         ACT_LOAD: begin
            grant_d  = win;
            idx_d    = win_idx;
            credit_d = load_credit;
            ptr_d    = win_idx;
         end
         ACT_IDLE: begin
            grant_d  = '0;
            idx_d    = '0;
            credit_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grant_q  <= '0;
         idx_q    <= '0;
         credit_q <= '0;
         ptr_q    <= IDX_W'(CLIENTS-1);
      end else begin
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         credit_q <= credit_d;
         ptr_q    <= ptr_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_idx   = idx_q;
   assign credit      = credit_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter (4 clients, 3-bit weights): directed scenarios plus
// random traffic, all checked every cycle against an arithmetic reference model.
module tb_wrr_arbiter;

   localparam int N  = 4;
   localparam int WW = 3;
   localparam int IW = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    request;
   logic [N*WW-1:0] weight;
   logic            stall;
   logic [N-1:0]    grant;
   logic            grant_valid;
   logic [IW-1:0]   grant_idx;
   logic [WW-1:0]   credit;

   int tests = 0;
   int fails = 0;

   int m_owner;
   int m_credit;
   int m_ptr;

   wrr_arbiter #(
      .CLIENTS  (N),
      .WEIGHT_W (WW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .request     (request),
      .weight      (weight),
      .stall       (stall),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .credit      (credit)
   );

   always #5 clock = ~clock;

   function automatic logic [N*WW-1:0] pw(input int w0, input int w1, input int w2, input int w3);
      return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic [N-1:0] r, input logic [N*WW-1:0] w,
                               input logic s, input logic rs);
      int wv;
      if (rs) begin
         m_owner  = -1;
         m_credit = 0;
         m_ptr    = N - 1;
      end else if (!s) begin
         if (m_owner >= 0 && r[m_owner] && m_credit > 1) begin
            m_credit = m_credit - 1;
         end else begin
            m_owner  = -1;
            m_credit = 0;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (m_owner < 0 && r[c]) begin
                  m_owner  = c;
                  wv       = int'(w[c*WW +: WW]);
                  m_credit = (wv == 0) ? 1 : wv;
               end
            end
            if (m_owner >= 0) m_ptr = m_owner;
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic [N*WW-1:0] w,
                       input logic s, input logic rs);
      logic [N-1:0] eg;
      @(negedge clock);
      request = r;
      weight  = w;
      stall   = s;
      reset   = rs;
      @(posedge clock);
      model_update(r, w, s, rs);
      #1;
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("grant_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("credit", 32'(credit), 32'(m_credit));
   endtask

   task automatic lit(input string tag, input logic [N-1:0] g, input int c);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_credit"}, 32'(credit), 32'(c));
   endtask

   initial begin
      logic [N*WW-1:0] w;
      m_owner  = -1;
      m_credit = 0;
      m_ptr    = N - 1;
      request  = '0;
      weight   = '0;
      stall    = 1'b0;
      reset    = 1'b1;

      // reset state
      step(4'b0000, pw(1,1,1,1), 1'b0, 1'b1);
      lit("reset", 4'b0000, 0);
      chk("reset_idx", 32'(grant_idx), 32'd0);

      // plain rotation, all weights 1
      w = pw(1,1,1,1);
      step(4'b1111, w, 1'b0, 1'b0); lit("rot0", 4'b0001, 1);
      step(4'b1111, w, 1'b0, 1'b0); lit("rot1", 4'b0010, 1);
      step(4'b1111, w, 1'b0, 1'b0); lit("rot2", 4'b0100, 1);
      step(4'b1111, w, 1'b0, 1'b0); lit("rot3", 4'b1000, 1);
      step(4'b1111, w, 1'b0, 1'b0); lit("rot4", 4'b0001, 1);
      chk("rot4_idx", 32'(grant_idx), 32'd0);

      // weighted bursts
      step(4'b0000, w, 1'b0, 1'b1);
      w = pw(3,1,2,1);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb0", 4'b0001, 3);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb1", 4'b0001, 2);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb2", 4'b0001, 1);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb3", 4'b0100, 2);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb4", 4'b0100, 1);
      step(4'b0101, w, 1'b0, 1'b0); lit("wb5", 4'b0001, 3);

      // owner drops request mid-burst
      step(4'b0000, w, 1'b0, 1'b1);
      w = pw(2,1,4,1);
      step(4'b0101, w, 1'b0, 1'b0); lit("drop0", 4'b0001, 2);
      step(4'b0101, w, 1'b0, 1'b0); lit("drop1", 4'b0001, 1);
      step(4'b0101, w, 1'b0, 1'b0); lit("drop2", 4'b0100, 4);
      step(4'b0101, w, 1'b0, 1'b0); lit("drop3", 4'b0100, 3);
      step(4'b0001, w, 1'b0, 1'b0); lit("drop4", 4'b0001, 2);

      // stall freezes mid-burst even with request/weight changing
      step(4'b0000, w, 1'b0, 1'b1);
      w = pw(1,3,1,1);
      step(4'b0010, w, 1'b0, 1'b0); lit("st0", 4'b0010, 3);
      step(4'b0010, w, 1'b0, 1'b0); lit("st1", 4'b0010, 2);
      step(4'b1111, pw(5,6,7,0), 1'b1, 1'b0); lit("st2", 4'b0010, 2);
      step(4'b0000, pw(5,6,7,0), 1'b1, 1'b0); lit("st3", 4'b0010, 2);
      step(4'b1101, pw(5,6,7,0), 1'b1, 1'b0); lit("st4", 4'b0010, 2);
      chk("st4_idx", 32'(grant_idx), 32'd1);
      step(4'b0011, w, 1'b0, 1'b0); lit("st5", 4'b0010, 1);
      step(4'b0011, w, 1'b0, 1'b0); lit("st6", 4'b0001, 1);

      // zero weight saturates to 1, sole requester regranted, then idle
      step(4'b0000, w, 1'b0, 1'b1);
      w = pw(1,0,1,1);
      step(4'b0010, w, 1'b0, 1'b0); lit("zw0", 4'b0010, 1);
      step(4'b0010, w, 1'b0, 1'b0); lit("zw1", 4'b0010, 1);
      step(4'b0010, w, 1'b0, 1'b0); lit("zw2", 4'b0010, 1);
      step(4'b0000, w, 1'b0, 1'b0); lit("zw3", 4'b0000, 0);
      chk("zw3_valid", 32'(grant_valid), 32'd0);

      // reset mid-burst
      w = pw(1,1,1,3);
      step(4'b1000, w, 1'b0, 1'b0); lit("rb0", 4'b1000, 3);
      step(4'b1000, w, 1'b0, 1'b1); lit("rb1", 4'b0000, 0);
      step(4'b1001, w, 1'b0, 1'b0); lit("rb2", 4'b0001, 1);

      // random traffic against the reference model
      for (int n = 0; n < 1500; n++) begin
         logic [N-1:0] r;
         r = N'($urandom_range(0, 15));
         w = pw($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
         step(r, w, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
         chk("onehot", 32'($onehot0(grant)), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
